mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit that produces the HI/LO pair for MULT/MULTU/DIV/DIVU.
//  Operands come from the MDSrcA/MDSrcB muxes and are accepted with a start/done handshake.
//  The unit stalls the multi-cycle control unit while busy and raises div0 for the divide-by-zero exception path.
//  It replaces the fixed 32-bit mult/div path with a width-generic, radix-2 sequential engine.
// PARAMETERS
//  WIDTH    32               operand width; hi/lo are WIDTH each, product is 2*WIDTH
//  CNT_W    $clog2(WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//  clock    in   1      system clock, rising edge
//  reset    in   1      asynchronous, active-low reset
//  start    in   1      1-cycle request; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (captured with start)
//  src_a    in   WIDTH  multiplicand / dividend (captured with start)
//  src_b    in   WIDTH  multiplier / divisor (captured with start)
//  busy     out  1      high from the cycle after start is accepted until done
//  done     out  1      1-cycle pulse; hi/lo are valid from this cycle on
//  div0     out  1      1-cycle pulse, concurrent with done, on DIV/DIVU with src_b==0
//  hi       out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo       out  WIDTH  MULT: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//  Reset (async, low): state=IDLE; busy, done, div0 = 0; hi, lo = 0; counter = 0.
//  States: IDLE -> RUN -> FIX -> IDLE.
//   - IDLE, start=1, division with src_b==0: go to FIX with the zero flag set.
//     Next cycle: done=1, div0=1, hi/lo keep their previous values. Latency 2.
//   - IDLE, start=1, otherwise: latch |a| and |b| (magnitudes for signed ops), latch the result signs,
//     counter=WIDTH, go to RUN.
//   - RUN: one radix-2 step per cycle (shift-add for mult, restoring subtract for div); counter decrements.
//     On the step where counter reaches 0, go to FIX.
//   - FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
//  Latency: start at cycle 0 -> done at cycle WIDTH+2. The next start is accepted in the cycle after done.
//  Signs:
//   - MULT: product negated if sign(a)^sign(b).
//   - DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a), truncating division.
//  MIN/-1 case: DIV of 0x80..0 by -1 yields lo=0x80..0, hi=0, with no flag raised.
//  Unsigned ops never negate. Arithmetic is internal at 2*WIDTH; hi/lo are exact truncations.
//  start while busy (RUN/FIX): ignored, no queueing. op/src changes after acceptance have no effect.
//  done and div0 are single-cycle pulses and never back-to-back without an intervening start.
//  Reset asserted mid-operation: immediate abort to reset values; no done is produced.
// CONFIGURATION
//  MD_EARLY_TERM_EN defined:
//   - MULT/MULTU leave RUN as soon as the remaining multiplier bits are all zero (FIX follows).
//   - Latency becomes variable, from 2 (src_b==0) to WIDTH+2; the result is identical.
//  MD_EARLY_TERM_EN undefined: every multiply takes exactly WIDTH+2 cycles.
//  Division latency is fixed at WIDTH+2 in both builds.
// STRUCTURE
//  md_pkg holds:
//   - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
//   - state encoding: MD_IDLE, MD_RUN, MD_FIX;
//   - default WIDTH.
//  Sub-module md_div_step: combinational single restoring-division step.
//   - Inputs: partial remainder, divisor. Outputs: next remainder, quotient bit.
//  The FSM, counter, shift registers and sign correction all stay in mult_div_unit.
// TESTING
//  1 MULT a=-3 (0xFFFFFFFD) b=7 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div0=0.
//  2 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100 b=7 -> lo=14, hi=2.
//  4 DIV a=5 b=0 with prior hi=lo=0x1234 -> done+div0 at cycle 2; hi/lo still 0x1234.
//  5 start pulsed again at cycle 10 of a DIV -> ignored; single done at cycle 34.
//    Reset at cycle 15 of a second op -> outputs 0, no done.
//  6 MD_EARLY_TERM_EN build: MULTU a=9 b=3 -> lo=27, done at cycle 4; same op without macro -> cycle 34.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and default width for the multiply/divide unit
package md_pkg;
  localparam int MD_WIDTH = 32;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  localparam logic [1:0] MD_IDLE  = 2'b00;
  localparam logic [1:0] MD_RUN   = 2'b01;
  localparam logic [1:0] MD_FIX   = 2'b10;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/done request bus between control unit and multiply/divide unit
interface mult_div_unit_if import md_pkg::*; #(parameter int WIDTH = MD_WIDTH);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, src_a, src_b, input busy, done, div0, hi, lo);
  modport slave  (input start, op, src_a, src_b, output busy, done, div0, hi, lo);
endinterface

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division step
module md_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] diff;
  // rem_i < 2*divisor, so a negative difference always shows in bit WIDTH
  always_comb begin
    diff  = rem_i - {1'b0, div_i};
    q_o   = !diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 iterative MULT/MULTU/DIV/DIVU engine; MD_EARLY_TERM_EN enables early multiply exit
module mult_div_unit import md_pkg::*; #(parameter int WIDTH = MD_WIDTH) (
  input logic clock,
  input logic reset,
  mult_div_unit_if.slave md
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MD_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, a_q, a_d, prod;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, rem_n;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic done_q, done_d, div0_q, div0_d, sign_a, sign_b, is_div, q_bit;
  assign is_div  = md.op[1];
  assign sign_a  = !md.op[0] && md.src_a[WIDTH-1];
  assign sign_b  = !md.op[0] && md.src_b[WIDTH-1];
  assign mag_a   = sign_a ? -md.src_a : md.src_a;
  assign mag_b   = sign_b ? -md.src_b : md.src_b;
  assign md.busy = state_q != MD_IDLE;
  assign md.done = done_q;
  assign md.div0 = div0_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  md_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i({acc_q[WIDTH-1:0], b_q[WIDTH-1]}),
    .div_i(a_q[WIDTH-1:0]),
    .rem_o(rem_n),
    .q_o  (q_bit)
  );
  // FSM: accept in IDLE (not in the done cycle), iterate in RUN, sign-correct and publish in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    prod    = neg_q ? -acc_q : acc_q;
    if (state_q == MD_IDLE) begin
      if (md.start && !done_q) begin
        div_d   = is_div;
        neg_d   = sign_a ^ sign_b;
        rneg_d  = sign_a;
        zero_d  = is_div && md.src_b == '0;
        acc_d   = '0;
        cnt_d   = CNT_W'(WIDTH);
        a_d     = {{WIDTH{1'b0}}, is_div ? mag_b : mag_a};
        b_d     = is_div ? mag_a : mag_b;
        state_d = (zero_d || (EARLY && !is_div && md.src_b == '0)) ? MD_FIX : MD_RUN;
      end
    end else if (state_q == MD_RUN) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        acc_d = {{WIDTH{1'b0}}, rem_n};
        b_d   = {b_q[WIDTH-2:0], q_bit};
      end else begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
      end
      if (cnt_q == CNT_W'(1) || (EARLY && !div_q && b_q[WIDTH-1:1] == '0)) state_d = MD_FIX;
    end else begin
      state_d = MD_IDLE;
      done_d  = 1'b1;
      div0_d  = zero_q;
      if (!zero_q) begin
        hi_d = div_q ? (rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[2*WIDTH-1:WIDTH];
        lo_d = div_q ? (neg_q ? -b_q : b_q) : prod[WIDTH-1:0];
      end
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit
module tb_mult_div_unit;
  import md_pkg::*;
`ifdef MD_EARLY_TERM_EN
  localparam int LAT_M93 = 4;
  localparam int LAT_M0  = 2;
`else
  localparam int LAT_M93 = 34;
  localparam int LAT_M0  = 34;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passes = 0;
  always #5 clock = ~clock;
  mult_div_unit_if md ();
  mult_div_unit dut (.clock(clock), .reset(reset), .md(md));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    md.start = 1'b1;
    md.op    = op;
    md.src_a = a;
    md.src_b = b;
    @(negedge clock);
    md.start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!md.done && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ez, input int lat);
    int n;
    issue(op, a, b);
    check({tag, " busy"}, md.busy, 1);
    wait_done(n);
    check({tag, " lat"}, n, lat);
    check({tag, " hi"}, md.hi, eh);
    check({tag, " lo"}, md.lo, el);
    check({tag, " div0"}, md.div0, ez);
    @(negedge clock);
    check({tag, " done pulse"}, md.done, 0);
  endtask
  initial begin
    int n;
    int dones;
    md.start = 1'b0;
    md.op    = MD_MULT;
    md.src_a = '0;
    md.src_b = '0;
    repeat (2) @(negedge clock);
    check("rst busy", md.busy, 0);
    check("rst done", md.done, 0);
    check("rst div0", md.div0, 0);
    check("rst hi", md.hi, 0);
    check("rst lo", md.lo, 0);
    reset = 1'b1;
    run("mult -3*7", MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34);
    run("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 34);
    run("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
    run("div 7/-2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 34);
    run("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34);
    run("div min/-1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 34);
    run("divu setup", MD_DIVU, 32'h12341234, 32'h00010000, 32'h1234, 32'h1234, 0, 34);
    run("div by 0", MD_DIV, 32'd5, 32'd0, 32'h1234, 32'h1234, 1, 2);
    run("divu by 0", MD_DIVU, 32'd9, 32'd0, 32'h1234, 32'h1234, 1, 2);
    run("multu 9*3", MD_MULTU, 32'd9, 32'd3, 32'd0, 32'd27, 0, LAT_M93);
    run("mult 5*0", MD_MULT, 32'd5, 32'd0, 32'd0, 32'd0, 0, LAT_M0);
    run("mult -1*-1", MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 0, 34);
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    md.start = 1'b1;
    md.op    = MD_MULTU;
    md.src_a = 32'd1;
    md.src_b = 32'd1;
    @(negedge clock);
    md.start = 1'b0;
    n = 11;
    while (!md.done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("busy start lat", n, 34);
    check("busy start hi", md.hi, 2);
    check("busy start lo", md.lo, 14);
    dones = 0;
    repeat (5) begin
      @(negedge clock);
      if (md.done || md.busy) dones++;
    end
    check("no queued op", dones, 0);
    issue(MD_DIV, 32'd50, 32'd3);
    repeat (14) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort busy", md.busy, 0);
    check("abort done", md.done, 0);
    check("abort hi", md.hi, 0);
    check("abort lo", md.lo, 0);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (md.done) dones++;
    end
    check("abort no done", dones, 0);
    run("after abort", MD_DIV, 32'd50, 32'd3, 32'd2, 32'd16, 0, 34);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
